// File: rtl/bin2bcd_stream_pkg.sv
// bcd_pkg: shared FSM state type and elaboration-time helpers for the BCD converter
package bcd_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction
endpackage

// File: rtl/bin2bcd_stream_if.sv
// bin2bcd_stream_if: input/output handshake bundle of the streaming BCD converter
interface bin2bcd_stream_if #(parameter int DATA_W = 10, parameter int BCD_DIGITS = 4);
  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_W-1:0]       in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [4*BCD_DIGITS-1:0] bcd_data;
  logic                    overflow;
  logic [BCD_DIGITS-1:0]   lead_mask;
  modport master(output in_valid, in_data, out_ready, input in_ready, out_valid, bcd_data, overflow, lead_mask);
  modport slave(input in_valid, in_data, out_ready, output in_ready, out_valid, bcd_data, overflow, lead_mask);
endinterface

// File: rtl/bin2bcd_stream_digit_adj.sv
// bcd_digit_adj: double-dabble nibble correction, add 3 when the digit is 5 or more
module bcd_digit_adj (
  input  logic [3:0] d,
  output logic [3:0] q
);
  assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

// File: rtl/bin2bcd_stream.sv
// bin2bcd_stream: serial double-dabble binary to packed BCD with valid/ready handshakes
module bin2bcd_stream
  import bcd_pkg::*;
#(
  parameter int DATA_W     = 10,
  parameter int BCD_DIGITS = 4
) (
  input  logic sys_clk,
  input  logic sys_rst,
  bin2bcd_stream_if.slave bus
);
  localparam int BW   = 4 * BCD_DIGITS;
  localparam int SR_W = DATA_W + BW;
  localparam int CW   = cnt_w(DATA_W);
  localparam logic [63:0] LIMIT = pow10(BCD_DIGITS);
  state_t state, state_n;
  logic [SR_W-1:0] sr, sr_adj, sr_nx;
  logic [CW-1:0] cnt;
  logic ovf_lat, ovf_q, z;
  logic [BW-1:0] bcd_q, bcd_nx;
  logic [BCD_DIGITS-1:0] lm_q, lm_nx;
  logic accept, last;
  assign accept = (state == IDLE) && bus.in_valid;
  assign last = (state == SHIFT) && (cnt == CW'(1));
  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (.d(sr[DATA_W+4*g +: 4]), .q(sr_adj[DATA_W+4*g +: 4]));
  end
  assign sr_adj[DATA_W-1:0] = sr[DATA_W-1:0];
  assign sr_nx = {sr_adj[SR_W-2:0], 1'b0};
  assign bcd_nx = ovf_lat ? {BCD_DIGITS{4'h9}} : sr_nx[SR_W-1 -: BW];
  // mark digits that sit above the most significant nonzero digit
  always_comb begin
    lm_nx = '0;
    z = 1'b1;
    for (int i = BCD_DIGITS - 1; i > 0; i--) begin
      z = z && (bcd_nx[4*i +: 4] == 4'h0);
      lm_nx[i] = z;
    end
  end
  // next-state decode
  always_comb begin
    state_n = accept ? SHIFT : last ? DONE : (state == DONE && bus.out_ready) ? IDLE : state;
  end
  // state register
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state <= IDLE;
    else state <= state_n;
  end
  // load on accept, one adjust-and-shift per SHIFT cycle, capture result on the last shift
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sr <= '0;
      cnt <= '0;
      ovf_lat <= 1'b0;
      ovf_q <= 1'b0;
      bcd_q <= '0;
      lm_q <= '0;
    end else if (accept) begin
      sr <= SR_W'(bus.in_data);
      cnt <= CW'(DATA_W);
      ovf_lat <= 64'(bus.in_data) >= LIMIT;
    end else if (state == SHIFT) begin
      sr <= sr_nx;
      cnt <= cnt - CW'(1);
      if (last) begin
        bcd_q <= bcd_nx;
        ovf_q <= ovf_lat;
        lm_q <= lm_nx;
      end
    end
  end
  assign bus.in_ready = state == IDLE;
  assign bus.out_valid = state == DONE;
  assign bus.bcd_data = bcd_q;
  assign bus.overflow = ovf_q;
  assign bus.lead_mask = lm_q;
endmodule

// File: tb/tb_bin2bcd_stream.sv
// tb_bin2bcd_stream: directed and random checks of three converter configurations against an arithmetic model
module tb_bin2bcd_stream;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int errors = 0;
  int checks = 0;
  int dw[3] = '{10, 10, 16};
  int dig[3] = '{4, 3, 5};
  logic in_valid[3];
  logic out_ready[3];
  logic [31:0] in_data[3];
  logic ov[3];
  logic ir[3];
  logic ovf[3];
  logic [63:0] bcd[3];
  logic [15:0] lm[3];
  bin2bcd_stream_if #(.DATA_W(10), .BCD_DIGITS(4)) ia();
  bin2bcd_stream_if #(.DATA_W(10), .BCD_DIGITS(3)) ib();
  bin2bcd_stream_if #(.DATA_W(16), .BCD_DIGITS(5)) ic();
  bin2bcd_stream #(.DATA_W(10), .BCD_DIGITS(4)) da (.sys_clk(clk), .sys_rst(rst), .bus(ia));
  bin2bcd_stream #(.DATA_W(10), .BCD_DIGITS(3)) db (.sys_clk(clk), .sys_rst(rst), .bus(ib));
  bin2bcd_stream #(.DATA_W(16), .BCD_DIGITS(5)) dc (.sys_clk(clk), .sys_rst(rst), .bus(ic));
  assign ia.in_valid = in_valid[0];
  assign ia.in_data = in_data[0][9:0];
  assign ia.out_ready = out_ready[0];
  assign ib.in_valid = in_valid[1];
  assign ib.in_data = in_data[1][9:0];
  assign ib.out_ready = out_ready[1];
  assign ic.in_valid = in_valid[2];
  assign ic.in_data = in_data[2][15:0];
  assign ic.out_ready = out_ready[2];
  assign ov[0] = ia.out_valid;
  assign ov[1] = ib.out_valid;
  assign ov[2] = ic.out_valid;
  assign ir[0] = ia.in_ready;
  assign ir[1] = ib.in_ready;
  assign ir[2] = ic.in_ready;
  assign ovf[0] = ia.overflow;
  assign ovf[1] = ib.overflow;
  assign ovf[2] = ic.overflow;
  assign bcd[0] = 64'(ia.bcd_data);
  assign bcd[1] = 64'(ib.bcd_data);
  assign bcd[2] = 64'(ic.bcd_data);
  assign lm[0] = 16'(ia.lead_mask);
  assign lm[1] = 16'(ib.lead_mask);
  assign lm[2] = 16'(ic.lead_mask);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // decimal digits by division; saturate to nines and clear the mask on overflow
  task automatic model(input longint v, input int d, output logic [63:0] b, output logic e, output logic [15:0] m);
    longint p = 1;
    longint lim = 1;
    for (int i = 0; i < d; i++) lim = lim * 10;
    e = v >= lim;
    b = '0;
    m = '0;
    for (int i = 0; i < d; i++) begin
      b = b | ((e ? 64'h9 : 64'((v / p) % 10)) << (4 * i));
      m[i] = (i > 0) && !e && (v / p == 0);
      p = p * 10;
    end
  endtask

  task automatic run(input int k, input longint v, input int hold);
    int n;
    logic stable;
    logic [63:0] eb;
    logic eo;
    logic [15:0] el;
    model(v, dig[k], eb, eo, el);
    @(negedge clk);
    check("in_ready_idle", 64'(ir[k]), 64'd1);
    in_data[k] = 32'(v);
    in_valid[k] = 1'b1;
    out_ready[k] = 1'b0;
    @(posedge clk);
    #1 in_valid[k] = 1'b0;
    in_data[k] = $urandom;
    n = 0;
    while (!ov[k] && n < 100) begin
      @(posedge clk);
      #1 n++;
    end
    check("latency", 64'(n), 64'(dw[k]));
    check("bcd_data", bcd[k], eb);
    check("overflow", 64'(ovf[k]), 64'(eo));
    check("lead_mask", 64'(lm[k]), 64'(el));
    if (hold > 0) begin
      stable = 1'b1;
      repeat (hold) begin
        in_valid[k] = 1'b1;
        in_data[k] = $urandom;
        @(posedge clk);
        #1 stable = stable && ov[k] && !ir[k] && bcd[k] == eb && ovf[k] == eo && lm[k] == el;
      end
      in_valid[k] = 1'b0;
      check("hold_stable", 64'(stable), 64'd1);
    end
    @(negedge clk);
    out_ready[k] = 1'b1;
    @(posedge clk);
    #1 out_ready[k] = 1'b0;
    check("release_ready", 64'(ir[k]), 64'd1);
    check("release_valid", 64'(ov[k]), 64'd0);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      in_valid[k] = 1'b0;
      out_ready[k] = 1'b0;
      in_data[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1 check("rst_out_valid", 64'(ov[0]), 64'd0);
    check("rst_bcd", bcd[0], 64'd0);
    check("rst_lead_mask", 64'(lm[0]), 64'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1 check("first_in_ready", 64'(ir[0]), 64'd1);
    run(0, 999, 0);
    run(0, 0, 0);
    run(0, 123, 20);
    run(0, 9, 0);
    run(1, 1023, 0);
    run(1, 999, 0);
    run(1, 1000, 0);
    run(1, 40, 0);
    run(0, 1023, 0);
    @(negedge clk);
    in_data[0] = 32'd512;
    in_valid[0] = 1'b1;
    @(posedge clk);
    #1 in_valid[0] = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1 check("arst_out_valid", 64'(ov[0]), 64'd0);
    check("arst_bcd", bcd[0], 64'd0);
    check("arst_overflow", 64'(ovf[0]), 64'd0);
    check("arst_lead_mask", 64'(lm[0]), 64'd0);
    check("arst_in_ready", 64'(ir[0]), 64'd1);
    @(negedge clk) rst = 1'b0;
    run(0, 37, 0);
    run(2, 65535, 0);
    run(2, 0, 0);
    run(2, 10000, 1);
    for (int r = 0; r < 20; r++) run(2, longint'($urandom_range(0, 65535)), int'($urandom_range(0, 2)));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bin2bcd_stream.md
BIN2BCD_STREAM -- requirements
Module: bin2bcd_stream

Interface
REQ-001 Parameter DATA_W, default 10, width of the unsigned binary input (range 4..32).
REQ-002 Parameter BCD_DIGITS, default 4, number of packed BCD output digits (range 1..10).
REQ-003 sys_clk  input  1  single clock; all state updates on its rising edge.
REQ-004 sys_rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  in_data is valid this cycle.
REQ-006 in_ready  output  1  block can accept a new value.
REQ-007 in_data  input  DATA_W  unsigned binary value to convert.
REQ-008 out_valid  output  1  bcd_data, overflow and lead_mask are valid.
REQ-009 out_ready  input  1  consumer accepts the result.
REQ-010 bcd_data  output  4*BCD_DIGITS  packed BCD result; digit 0 (units) in bits [3:0].
REQ-011 overflow  output  1  input value exceeded 10^BCD_DIGITS-1.
REQ-012 lead_mask  output  BCD_DIGITS  bit i set when digit i is a leading zero; bit 0 is always 0.

Function
REQ-013 The block SHALL implement the FSM states IDLE, SHIFT and DONE.
REQ-014 In IDLE, in_ready=1; in SHIFT and DONE, in_ready=0.
REQ-015 Handshake in_valid&&in_ready SHALL load the shift register with {zeros, in_data}, load the bit counter with DATA_W, latch the overflow compare, and move the FSM to SHIFT.
REQ-016 Each SHIFT cycle SHALL add 3 to every BCD nibble whose value is >=5, then shift the whole register left by 1, and decrement the counter; all of this happens in one clock.
REQ-017 When the counter is 1 in SHIFT, the FSM SHALL move to DONE and register bcd_data, overflow and lead_mask.
REQ-018 out_valid SHALL rise exactly DATA_W clocks after the accept edge, and SHALL equal 1 only in DONE.
REQ-019 While out_valid=1, bcd_data, overflow and lead_mask SHALL remain stable until out_valid&&out_ready.
REQ-020 On out_valid&&out_ready the FSM SHALL return to IDLE; in_ready=1 on the next cycle.
REQ-021 No new value is accepted in the same cycle as output release; sustained throughput SHALL be one conversion per DATA_W+2 cycles.
REQ-022 Overflow: if in_data >= 10^BCD_DIGITS, overflow=1 and bcd_data SHALL saturate to all nines; otherwise overflow=0.
REQ-023 The compare constant SHALL be computed at elaboration at sufficient width, so no truncation occurs when 10^BCD_DIGITS exceeds 2^DATA_W.
REQ-024 The shift register width SHALL be DATA_W+4*BCD_DIGITS; nibble adjust arithmetic SHALL be 4-bit, with no carry between nibbles.
REQ-025 lead_mask[i]=1 iff digits i..BCD_DIGITS-1 are all zero and i>0; for value 0, the mask is all ones except bit 0.
REQ-026 in_data and in_valid changes outside an accept cycle SHALL have no effect on a conversion in progress.

Reset
REQ-027 Asserting sys_rst at any time, including mid-SHIFT or in DONE, SHALL immediately force the following: state IDLE, counter 0, shift register 0, bcd_data 0, overflow 0, lead_mask 0, out_valid 0.
REQ-028 After reset deassertion, in_ready SHALL be 1 on the first clock edge.

Structure
REQ-029 A package bcd_pkg SHALL hold the FSM state typedef, a pow10 constant function and the counter-width function.
REQ-030 Nibble adjust SHALL be a sub-module bcd_digit_adj (4-bit in, 4-bit out, combinational add-3-if->=5), instantiated BCD_DIGITS times via generate.
REQ-031 All outputs SHALL be driven from registers, except in_ready and out_valid, which are decoded from the state register.

Verification
REQ-032 Defaults (10/4), in_data=999, out_ready=1 -> out_valid 10 clocks after accept; bcd_data=16'h0999; overflow=0; lead_mask=4'b1000.
REQ-033 DATA_W=10, BCD_DIGITS=3, in_data=1023 -> overflow=1; bcd_data=12'h999.
REQ-034 in_data=0 -> bcd_data=0; lead_mask=4'b1110.
REQ-035 out_ready held 0 for 20 clocks after out_valid -> outputs stable; in_ready=0; a new in_valid is ignored; release -> in_ready=1 next clock.
REQ-036 sys_rst pulsed at SHIFT cycle 5 of a conversion of 512 -> all outputs 0 asynchronously; a subsequent conversion of 37 yields 16'h0037.
REQ-037 DATA_W=16, BCD_DIGITS=5; random sweep plus 65535 -> bcd_data=20'h65535, overflow=0, matching a reference model.
